decode_session_controller: RTL and testbench

DECODE_SESSION_CONTROLLER -- requirements
Module: decode_session_controller

---
 rtl/decode_session_controller_pkg.sv | 25 ++
 rtl/decode_session_controller.sv | 154 +++++++++++++++
 tb/tb_decode_session_controller.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_session_controller_pkg.sv
// Shared decoder-protocol constants and the session state encoding.
package decode_session_controller_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;

    // Decoder answers every syndrome with iterations, cycles[15:8], cycles[7:0].
    localparam int RESULT_BYTES = 3;

    typedef enum logic [2:0] {
        IDLE,
        SEND_START,
        SEND_HDR,
        STREAM,
        RECV,
        REPORT,
        ERROR
    } state_t;

    // Bytes of measurement data per syndrome: one byte-padded grid slice per round.
    function automatic int meas_bytes(input int gx, input int gz, input int gu);
        return ((gx * gz + 7) >> 3) * gu;
    endfunction

endpackage

// File: rtl/decode_session_controller.sv
// Sequences a decode session: START once, then HDR + measurement bytes and a 3-byte result per syndrome.
// STREAM is a zero-latency pass-through (s_ready follows dec_in_ready); a result is held until res_ready.
module decode_session_controller
    import decode_session_controller_pkg::*;
#(
    parameter int GRID_WIDTH_X   = 4,
    parameter int GRID_WIDTH_Z   = 1,
    parameter int GRID_WIDTH_U   = 3,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] cfg_syndromes,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [7:0]  dec_in_data,
    output logic        dec_in_valid,
    input  logic        dec_in_ready,
    input  logic [7:0]  dec_out_data,
    input  logic        dec_out_valid,
    output logic        dec_out_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_iterations,
    output logic [15:0] res_cycles,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] done_count
);

    localparam int MEAS_BYTES = meas_bytes(GRID_WIDTH_X, GRID_WIDTH_Z, GRID_WIDTH_U);
    localparam int BC_W       = $clog2(MEAS_BYTES + 1);
    localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BC_W-1:0] MEAS_LAST = BC_W'(MEAS_BYTES - 1);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);
    localparam logic [1:0]      RX_LAST   = 2'(RESULT_BYTES - 1);

    state_t            state;
    state_t            state_next;
    logic [15:0]       syn_count;
    logic [BC_W-1:0]   byte_cnt;
    logic [1:0]        rx_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              more_syndromes;

    assign more_syndromes = ({1'b0, done_count} + 17'd1) < {1'b0, syn_count};

    always_comb begin
        state_next    = state;
        s_ready       = 1'b0;
        dec_in_valid  = 1'b0;
        dec_in_data   = 8'h00;
        dec_out_ready = 1'b0;
        res_valid     = 1'b0;
        busy          = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start && cfg_syndromes != 16'd0) state_next = SEND_START;
            end
            SEND_START: begin
                dec_in_valid = 1'b1;
                dec_in_data  = START_DECODING_MSG;
                if (dec_in_ready) state_next = SEND_HDR;
            end
            SEND_HDR: begin
                dec_in_valid = 1'b1;
                dec_in_data  = MEASUREMENT_DATA_HEADER;
                if (dec_in_ready) state_next = STREAM;
            end
            STREAM: begin
                dec_in_valid = s_valid;
                dec_in_data  = s_data;
                s_ready      = dec_in_ready;
                if (s_valid && dec_in_ready && byte_cnt == MEAS_LAST) state_next = RECV;
            end
            RECV: begin
                dec_out_ready = 1'b1;
                // A result completing on the watchdog's last cycle still wins.
                if (dec_out_valid && rx_cnt == RX_LAST) state_next = REPORT;
                else if (wd_cnt == WD_LAST)             state_next = ERROR;
            end
            REPORT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = more_syndromes ? SEND_HDR : IDLE;
            end
            ERROR: begin
                busy = 1'b0;
                if (start) state_next = (cfg_syndromes != 16'd0) ? SEND_START : IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            syn_count      <= 16'd0;
            byte_cnt       <= '0;
            rx_cnt         <= 2'd0;
            wd_cnt         <= '0;
            res_iterations <= 8'h00;
            res_cycles     <= 16'h0000;
            done_count     <= 16'd0;
            err_timeout    <= 1'b0;
        end else begin
            state <= state_next;

            if (state == IDLE && start && cfg_syndromes != 16'd0) begin
                syn_count  <= cfg_syndromes;
                done_count <= 16'd0;
            end

            if (state == ERROR && start) begin
                syn_count   <= cfg_syndromes;
                done_count  <= 16'd0;
                err_timeout <= 1'b0;
            end

            if (state == SEND_HDR) byte_cnt <= '0;

            if (state == STREAM && s_valid && dec_in_ready) byte_cnt <= byte_cnt + BC_ONE;

            if (state != RECV && state_next == RECV) begin
                rx_cnt <= 2'd0;
                wd_cnt <= '0;
            end

            if (state == RECV) begin
                wd_cnt <= wd_cnt + WD_ONE;
                if (dec_out_valid) begin
                    rx_cnt <= rx_cnt + 2'd1;
                    case (rx_cnt)
                        2'd0:    res_iterations   <= dec_out_data;
                        2'd1:    res_cycles[15:8] <= dec_out_data;
                        default: res_cycles[7:0]  <= dec_out_data;
                    endcase
                end
                if (state_next == ERROR) err_timeout <= 1'b1;
            end

            if (state == REPORT && res_ready) done_count <= done_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_decode_session_controller.sv
// Directed bench for decode_session_controller: host, decoder and result sink models around one DUT.
module tb_decode_session_controller;
    import decode_session_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_syndromes = 16'd0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  dec_in_data;
    logic        dec_in_valid;
    logic        dec_in_ready = 1'b1;
    logic [7:0]  dec_out_data = 8'h00;
    logic        dec_out_valid = 1'b0;
    logic        dec_out_ready;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [7:0]  res_iterations;
    logic [15:0] res_cycles;
    logic        busy;
    logic        err_timeout;
    logic [15:0] done_count;

    int errors = 0;
    int checks = 0;

    logic [7:0]  host_q[$];
    logic [7:0]  resp_q[$];
    logic [7:0]  din_q[$];
    logic [23:0] res_q[$];
    bit          stall_en = 1'b0;
    bit          s_hs = 1'b0;
    bit          o_hs = 1'b0;

    localparam int W_IDLE   = 0;
    localparam int W_RESVLD = 1;
    localparam int W_OUTRDY = 2;

    always #5 clk = ~clk;

    decode_session_controller #(
        .GRID_WIDTH_X  (4),
        .GRID_WIDTH_Z  (1),
        .GRID_WIDTH_U  (3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cfg_syndromes (cfg_syndromes),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .dec_in_data   (dec_in_data),
        .dec_in_valid  (dec_in_valid),
        .dec_in_ready  (dec_in_ready),
        .dec_out_data  (dec_out_data),
        .dec_out_valid (dec_out_valid),
        .dec_out_ready (dec_out_ready),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_iterations(res_iterations),
        .res_cycles    (res_cycles),
        .busy          (busy),
        .err_timeout   (err_timeout),
        .done_count    (done_count)
    );

    // Observe handshakes mid-cycle; they take effect at the following rising edge.
    always @(negedge clk) begin
        s_hs = !reset && s_valid && s_ready;
        o_hs = !reset && dec_out_valid && dec_out_ready;
        if (!reset && dec_in_valid && dec_in_ready) din_q.push_back(dec_in_data);
        if (!reset && res_valid && res_ready) res_q.push_back({res_iterations, res_cycles});
    end

    // Host source and decoder model, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (s_hs && host_q.size() > 0) void'(host_q.pop_front());
        if (o_hs && resp_q.size() > 0) void'(resp_q.pop_front());
        if (host_q.size() == 0) begin
            s_valid = 1'b0;
            s_data  = 8'h00;
        end else if (!s_valid || s_hs) begin
            if (!stall_en || $urandom_range(0, 2) != 0) begin
                s_valid = 1'b1;
                s_data  = host_q[0];
            end else begin
                s_valid = 1'b0;
            end
        end
        dec_in_ready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        dec_out_valid = resp_q.size() > 0;
        dec_out_data  = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
    end

    task automatic pulse_start(input logic [15:0] n);
        @(posedge clk); #1;
        cfg_syndromes = n;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_for(input int what, output bit ok);
        bit hit;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            case (what)
                W_IDLE:   hit = !busy;
                W_RESVLD: hit = res_valid;
                default:  hit = dec_out_ready;
            endcase
            if (hit) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, s_ready, dec_in_valid, dec_out_ready, res_valid, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, s_ready, dec_in_valid, dec_out_ready, res_valid, err_timeout});
        end
        checks++;
        if (dec_in_data !== 8'h00) begin errors++; $display("FAIL reset_dec_in_data: got %h want 00", dec_in_data); end
        checks++;
        if (done_count !== 16'd0) begin errors++; $display("FAIL reset_done_count: got %0d want 0", done_count); end
        checks++;
        if ({res_iterations, res_cycles} !== 24'h0) begin
            errors++; $display("FAIL reset_result: got %h want 000000", {res_iterations, res_cycles});
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_zero_cfg();
        din_q.delete();
        pulse_start(16'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zero_cfg_busy: got %b want 0", busy); end
        checks++;
        if (din_q.size() != 0) begin errors++; $display("FAIL zero_cfg_traffic: got %0d bytes want 0", din_q.size()); end
    endtask

    task automatic test_single();
        logic [7:0] exp[$];
        bit ok;
        din_q.delete(); res_q.delete();
        host_q = '{8'hA1, 8'hA2, 8'hA3};
        resp_q = '{8'h05, 8'h01, 8'h2C};
        exp    = '{START_DECODING_MSG, MEASUREMENT_DATA_HEADER, 8'hA1, 8'hA2, 8'hA3};
        pulse_start(16'd1);
        wait_for(W_IDLE, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL single_done: got busy=%b want 0 within budget", busy); end
        checks++;
        if (din_q.size() != exp.size()) begin
            errors++; $display("FAIL single_len: got %0d bytes want %0d", din_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (din_q[i] !== exp[i]) begin errors++; $display("FAIL single_byte%0d: got %h want %h", i, din_q[i], exp[i]); end
            end
        end
        checks++;
        if (res_iterations !== 8'd5) begin errors++; $display("FAIL single_iter: got %0d want 5", res_iterations); end
        checks++;
        if (res_cycles !== 16'd300) begin errors++; $display("FAIL single_cycles: got %0d want 300", res_cycles); end
        checks++;
        if (res_q.size() != 1) begin errors++; $display("FAIL single_results: got %0d want 1", res_q.size()); end
        checks++;
        if (done_count !== 16'd1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_count); end
        checks++;
        if (dec_in_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", dec_in_valid); end
    endtask

    task automatic test_multi();
        logic [7:0]  exp[$];
        logic [23:0] exp_res[3];
        int n_start;
        bit ok;
        din_q.delete(); res_q.delete();
        host_q  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
        resp_q  = '{8'h07, 8'h00, 8'h20, 8'h08, 8'h01, 8'h00, 8'h09, 8'hFF, 8'hFF};
        exp_res = '{24'h070020, 24'h080100, 24'h09FFFF};
        exp = '{START_DECODING_MSG, MEASUREMENT_DATA_HEADER, 8'h10, 8'h11, 8'h12,
                MEASUREMENT_DATA_HEADER, 8'h13, 8'h14, 8'h15,
                MEASUREMENT_DATA_HEADER, 8'h16, 8'h17, 8'h18};
        pulse_start(16'd3);
        wait_for(W_IDLE, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL multi_done: got busy=%b want 0 within budget", busy); end
        n_start = 0;
        foreach (din_q[i]) if (din_q[i] == START_DECODING_MSG) n_start++;
        checks++;
        if (n_start != 1) begin errors++; $display("FAIL multi_start_count: got %0d want 1", n_start); end
        checks++;
        if (din_q.size() != exp.size()) begin
            errors++; $display("FAIL multi_len: got %0d bytes want %0d", din_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (din_q[i] !== exp[i]) begin errors++; $display("FAIL multi_byte%0d: got %h want %h", i, din_q[i], exp[i]); end
            end
        end
        checks++;
        if (res_q.size() != 3) begin
            errors++; $display("FAIL multi_results: got %0d want 3", res_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (res_q[i] !== exp_res[i]) begin errors++; $display("FAIL multi_res%0d: got %h want %h", i, res_q[i], exp_res[i]); end
            end
        end
        checks++;
        if (done_count !== 16'd3) begin errors++; $display("FAIL multi_done_count: got %0d want 3", done_count); end
    endtask

    task automatic test_stalls();
        logic [7:0] exp[$];
        bit ok;
        din_q.delete(); res_q.delete();
        stall_en = 1'b1;
        host_q = '{8'h3C, 8'hA5, 8'h01, 8'h02, 8'hFE, 8'h80};
        resp_q = '{8'h03, 8'h00, 8'h40, 8'h04, 8'h12, 8'h34};
        exp = '{START_DECODING_MSG, MEASUREMENT_DATA_HEADER, 8'h3C, 8'hA5, 8'h01,
                MEASUREMENT_DATA_HEADER, 8'h02, 8'hFE, 8'h80};
        pulse_start(16'd2);
        wait_for(W_IDLE, ok);
        stall_en = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_done: got busy=%b want 0 within budget", busy); end
        checks++;
        if (din_q.size() != exp.size()) begin
            errors++; $display("FAIL stall_len: got %0d bytes want %0d", din_q.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (din_q[i] !== exp[i]) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, din_q[i], exp[i]); end
            end
        end
        checks++;
        if (res_q.size() != 2 || res_q[1] !== 24'h041234) begin
            errors++; $display("FAIL stall_results: got %0d entries want 2 ending 041234", res_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        din_q.delete(); res_q.delete();
        res_ready = 1'b0;
        host_q = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        resp_q = '{8'h0A, 8'hBE, 8'hEF, 8'h0B, 8'h00, 8'h01};
        pulse_start(16'd2);
        wait_for(W_RESVLD, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_res_valid: got 0 want 1 within budget"); end
        // A start pulse during a session must not disturb it.
        pulse_start(16'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({res_valid, res_iterations, res_cycles} !== {1'b1, 8'h0A, 16'hBEEF}) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b %h/%h want 1 0a/beef", i, res_valid, res_iterations, res_cycles);
            end
            checks++;
            if (din_q.size() != 5) begin errors++; $display("FAIL bp_no_hdr%0d: got %0d bytes want 5", i, din_q.size()); end
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_for(W_IDLE, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_done: got busy=%b want 0 within budget", busy); end
        checks++;
        if (din_q.size() != 9 || din_q[5] !== MEASUREMENT_DATA_HEADER) begin
            errors++; $display("FAIL bp_second_hdr: got %0d bytes want 9 with HDR at 5", din_q.size());
        end
        checks++;
        if (done_count !== 16'd2) begin errors++; $display("FAIL bp_done_count: got %0d want 2", done_count); end
        checks++;
        if (res_q.size() != 2 || res_q[0] !== 24'h0ABEEF || res_q[1] !== 24'h0B0001) begin
            errors++; $display("FAIL bp_results: got %0d entries want 0abeef,0b0001", res_q.size());
        end
    endtask

    task automatic test_timeout();
        bit ok;
        host_q = '{8'h31, 8'h32, 8'h33};
        resp_q.delete();
        pulse_start(16'd1);
        wait_for(W_OUTRDY, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL to_recv: got dec_out_ready=0 want 1 within budget"); end
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if ({dec_out_ready, err_timeout} !== 2'b10) begin
                errors++; $display("FAIL to_wait%0d: got rdy=%b err=%b want 1 0", i, dec_out_ready, err_timeout);
            end
        end
        @(negedge clk);
        checks++;
        if ({err_timeout, busy, dec_out_ready} !== 3'b100) begin
            errors++; $display("FAIL to_error: got err=%b busy=%b rdy=%b want 1 0 0", err_timeout, busy, dec_out_ready);
        end
        din_q.delete();
        host_q = '{8'h41, 8'h42, 8'h43};
        resp_q = '{8'h02, 8'h00, 8'h10};
        pulse_start(16'd1);
        @(negedge clk);
        checks++;
        if ({err_timeout, busy, done_count} !== {1'b0, 1'b1, 16'd0}) begin
            errors++; $display("FAIL to_restart: got err=%b busy=%b done=%0d want 0 1 0", err_timeout, busy, done_count);
        end
        wait_for(W_IDLE, ok);
        checks++;
        if (!ok || din_q.size() != 5 || din_q[0] !== START_DECODING_MSG) begin
            errors++; $display("FAIL to_rerun: got ok=%b %0d bytes want 1 and 5 starting with START", ok, din_q.size());
        end
        checks++;
        if (done_count !== 16'd1) begin errors++; $display("FAIL to_done_count: got %0d want 1", done_count); end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        din_q.delete();
        host_q = '{8'h55, 8'h66, 8'h77};
        resp_q.delete();
        pulse_start(16'd1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (din_q.size() >= 4) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL mid_stream_reach: got %0d bytes want 4", din_q.size()); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, s_ready, dec_in_valid, dec_out_ready, res_valid, err_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL mid_reset_flags: got %b want 000000",
                     {busy, s_ready, dec_in_valid, dec_out_ready, res_valid, err_timeout});
        end
        checks++;
        if (dec_in_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h want 00", dec_in_data); end
        checks++;
        if ({done_count, res_iterations, res_cycles} !== 40'h0) begin
            errors++; $display("FAIL mid_reset_regs: got %h want 0", {done_count, res_iterations, res_cycles});
        end
        checks++;
        if (dut.state !== IDLE) begin errors++; $display("FAIL mid_reset_state: got %0d want %0d", dut.state, IDLE); end
        host_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_release: got busy=%b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_zero_cfg();
        test_single();
        test_multi();
        test_stalls();
        test_backpressure();
        test_timeout();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation still running at %0t, limit 300000", $time);
        $fatal(1);
    end

endmodule
